// File: rtl/mem_pkg.sv
// Shared types for the RAM access master: FSM states and response payload.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_READ = 2'd2,
    RESP      = 2'd3
  } mem_state_t;

  // Data returned for stores and timed-out loads.
  localparam logic [31:0] RESP_ERR_DATA = 32'h0;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } mem_resp_t;

endpackage

// File: rtl/define.sv
// Project-wide defines shared by the RAM access path.
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

// File: rtl/ram_wait_timer.sv
// Saturating 8-bit wait counter for stalled reads. The expired flag fires
// on the MAX_WAIT-th consecutive enabled cycle, so a read spends at most
// MAX_WAIT cycles waiting before it is aborted.
module ram_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  logic [7:0] cnt_q;

  // Clear has priority; count up while enabled, stick at 255.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     cnt_q <= 8'd0;
    else if (clr)                  cnt_q <= 8'd0;
    else if (en && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end

  assign expired = en && (cnt_q >= LIMIT);

endmodule

// File: rtl/ram_access_master.sv
// Core-side RAM initiator: one outstanding load/store at a time, registered
// RAM port, bounded wait on read_ready, in-order single response per request.
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

module ram_access_master
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int ADDR_W   = `RAM_ADDRESS_BITWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_error,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic              ram_write_enable,
  output logic [31:0]       ram_write_data,
  input  logic [31:0]       ram_read_data,
  input  logic              ram_read_ready
);

  mem_state_t        state_q, state_d;
  mem_resp_t         resp_q, resp_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              we_q, we_d;
  logic              req_ready_q, resp_valid_q;
  logic              tmr_clr, tmr_en, tmr_expired;

  ram_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    resp_d    = resp_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we_d      = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            wr_addr_d = req_address;
            wr_data_d = req_wdata;
            we_d      = 1'b1;
            state_d   = WRITE;
          end else begin
            rd_addr_d = req_address;
            tmr_clr   = 1'b1;
            state_d   = WAIT_READ;
          end
        end
      end
      WRITE: begin
        resp_d  = '{data: RESP_ERR_DATA, error: 1'b0};
        state_d = RESP;
      end
      WAIT_READ: begin
        tmr_en = !ram_read_ready;
        // Data arriving on the expiry cycle still counts as a good read.
        if (ram_read_ready) begin
          resp_d  = '{data: ram_read_data, error: 1'b0};
          state_d = RESP;
        end else if (tmr_expired) begin
          resp_d  = '{data: RESP_ERR_DATA, error: 1'b1};
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers; handshake flags are decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_q       <= '{data: 32'h0, error: 1'b0};
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'h0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      resp_q       <= resp_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      we_q         <= we_d;
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_data         = resp_q.data;
  assign resp_error        = resp_q.error;
  assign ram_read_address  = rd_addr_q;
  assign ram_write_address = wr_addr_q;
  assign ram_write_enable  = we_q;
  assign ram_write_data    = wr_data_q;

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a combinational-ready RAM model.
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

module tb_ram_access_master;

  localparam int AW = `RAM_ADDRESS_BITWIDTH;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_ready, resp_error;
  logic [31:0]   resp_data;
  logic [AW-1:0] ram_read_address, ram_write_address;
  logic          ram_write_enable, ram_read_ready;
  logic [31:0]   ram_write_data, ram_read_data;

  logic          rr;
  logic [31:0]   mem [0:(1<<AW)-1];
  int            wr_pulses = 0;
  int            errors = 0;
  int            checks = 0;

  ram_access_master #(.MAX_WAIT(4), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .resp_error        (resp_error),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_write_enable  (ram_write_enable),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data),
    .ram_read_ready    (ram_read_ready)
  );

  always #5 clk = ~clk;

  assign ram_read_data  = mem[ram_read_address];
  assign ram_read_ready = rr;

  always @(posedge clk) begin
    if (ram_write_enable) begin
      mem[ram_write_address] <= ram_write_data;
      wr_pulses <= wr_pulses + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Present a request for exactly one accepting edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_address = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [31:0] d);
    issue(1'b1, a, d);
    tick();
    tick();
  endtask

  task automatic test_reset;
    rstn = 1'b1; #1 rstn = 1'b0; #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error: got %b want 0", resp_error); end
    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", ram_write_enable); end
    checks++; if (ram_read_address !== AW'(0)) begin errors++; $display("FAIL reset_raddr: got %h want 0", ram_read_address); end
    checks++; if (ram_write_address !== AW'(0)) begin errors++; $display("FAIL reset_waddr: got %h want 0", ram_write_address); end
    checks++; if (ram_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", ram_write_data); end
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_store;
    int p0;
    p0 = wr_pulses;
    req_valid = 1'b1; req_write = 1'b1; req_address = AW'('h10); req_wdata = 32'hDEADBEEF;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL store_ready_before: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (ram_write_enable !== 1'b1) begin errors++; $display("FAIL store_we_pulse: got %b want 1", ram_write_enable); end
    checks++; if (ram_write_address !== AW'('h10)) begin errors++; $display("FAIL store_waddr: got %h want 10", ram_write_address); end
    checks++; if (ram_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h want deadbeef", ram_write_data); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL store_ready_busy: got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL store_valid_early: got %b want 0", resp_valid); end
    tick();
    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL store_we_one_cycle: got %b want 0", ram_write_enable); end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL store_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL store_resp_data: got %h want 0", resp_data); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL store_resp_error: got %b want 0", resp_error); end
    checks++; if (wr_pulses !== p0 + 1) begin errors++; $display("FAIL store_pulse_count: got %0d want %0d", wr_pulses, p0 + 1); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL store_valid_drop: got %b want 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL store_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_store_then_load;
    issue(1'b0, AW'('h10), 32'h0);
    checks++; if (ram_read_address !== AW'('h10)) begin errors++; $display("FAIL load_raddr: got %h want 10", ram_read_address); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL load_valid_early: got %b want 0", resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL load_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_resp_data: got %h want deadbeef", resp_data); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL load_resp_error: got %b want 0", resp_error); end
    tick();
    checks++; if (ram_read_address !== AW'('h10)) begin errors++; $display("FAIL load_raddr_hold: got %h want 10", ram_read_address); end
  endtask

  // Three stalled cycles; ready lands on the cycle the timer would expire.
  task automatic test_read_stall;
    do_store(AW'('h20), 32'h12345678);
    rr = 1'b0;
    issue(1'b0, AW'('h20), 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_early[%0d]: got %b want 0", i, resp_valid); end
      tick();
    end
    rr = 1'b1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_early[3]: got %b want 0", resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_data !== 32'h12345678) begin errors++; $display("FAIL stall_resp_data: got %h want 12345678", resp_data); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL stall_ready_wins: got %b want 0", resp_error); end
    tick();
  endtask

  task automatic test_read_timeout;
    int p0;
    p0 = wr_pulses;
    rr = 1'b0;
    issue(1'b0, AW'('h20), 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid_early[%0d]: got %b want 0", i, resp_valid); end
      tick();
    end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL timeout_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_error !== 1'b1) begin errors++; $display("FAIL timeout_resp_error: got %b want 1", resp_error); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL timeout_resp_data: got %h want 0", resp_data); end
    checks++; if (wr_pulses !== p0) begin errors++; $display("FAIL timeout_no_write: got %0d want %0d", wr_pulses, p0); end
    tick();
    rr = 1'b1;
  endtask

  task automatic test_backpressure;
    int p0;
    resp_ready = 1'b0;
    issue(1'b0, AW'('h10), 32'h0);
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_valid: got %b want 1", resp_valid); end
    req_valid = 1'b1; req_write = 1'b1; req_address = AW'('h40); req_wdata = 32'hCAFEF00D;
    p0 = wr_pulses;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, resp_valid); end
      checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_data_hold[%0d]: got %h want deadbeef", i, resp_data); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
      checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL bp_no_accept[%0d]: got %b want 0", i, ram_write_enable); end
    end
    resp_ready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (ram_write_enable !== 1'b1) begin errors++; $display("FAIL bp_late_accept_we: got %b want 1", ram_write_enable); end
    checks++; if (ram_write_address !== AW'('h40)) begin errors++; $display("FAIL bp_late_accept_addr: got %h want 40", ram_write_address); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_late_resp: got %b want 1", resp_valid); end
    tick();
    checks++; if (wr_pulses !== p0 + 1) begin errors++; $display("FAIL bp_pulse_count: got %0d want %0d", wr_pulses, p0 + 1); end
  endtask

  task automatic test_reset_mid_op;
    int p0;
    rr = 1'b0;
    issue(1'b0, AW'('h30), 32'h0);
    tick();
    #2 rstn = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid: got %b want 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b want 1", req_ready); end
    checks++; if (ram_read_address !== AW'(0)) begin errors++; $display("FAIL rst_wait_raddr: got %h want 0", ram_read_address); end
    tick(); tick();
    rstn = 1'b1; rr = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_after: got %b want 0", resp_valid); end

    p0 = wr_pulses;
    issue(1'b1, AW'('h30), 32'h55AA55AA);
    checks++; if (ram_write_enable !== 1'b1) begin errors++; $display("FAIL rst_wr_pre_we: got %b want 1", ram_write_enable); end
    #2 rstn = 1'b0; #1;
    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL rst_wr_we: got %b want 0", ram_write_enable); end
    checks++; if (ram_write_address !== AW'(0)) begin errors++; $display("FAIL rst_wr_waddr: got %h want 0", ram_write_address); end
    checks++; if (ram_write_data !== 32'h0) begin errors++; $display("FAIL rst_wr_wdata: got %h want 0", ram_write_data); end
    tick();
    rstn = 1'b1;
    tick(); tick();
    checks++; if (wr_pulses !== p0) begin errors++; $display("FAIL rst_wr_no_pulse: got %0d want %0d", wr_pulses, p0); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wr_valid: got %b want 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b want 1", req_ready); end

    do_store(AW'('h30), 32'h55AA55AA);
    issue(1'b0, AW'('h30), 32'h0);
    tick();
    checks++; if (resp_data !== 32'h55AA55AA) begin errors++; $display("FAIL rst_recover_data: got %h want 55aa55aa", resp_data); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL rst_recover_error: got %b want 0", resp_error); end
    tick();
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = 32'h0;
    resp_ready = 1'b1; rr = 1'b1;
    test_reset();
    test_store();
    test_store_then_load();
    test_read_stall();
    test_read_timeout();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_access_master.md
Name: ram_access_master

Overview:
- Initiator-side controller that drives the shared RAM port (read/write address, write enable, write data) and consumes its read data and read-ready.
- Sits between the core's load/store stage and the RAM.
- Turns a valid/ready request from the core into RAM port activity, waits for read_ready, and returns one in-order response per request.
- Bounded wait: a stalled read is aborted and flagged as an error.

Parameters:
- MAX_WAIT, 15, maximum cycles spent in WAIT_READ (read_ready low) before abort; legal range 1..255.
- ADDR_W, `RAM_ADDRESS_BITWIDTH, request and RAM address width, taken from define.sv.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  ADDR_W  RAM address, passed unmodified to the RAM.
- req_wdata  in  32  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts the response.
- resp_data  out  32  load data; 0 for stores and errors.
- resp_error  out  1  read timed out.
- ram_read_address  out  ADDR_W  to RAM read_address.
- ram_write_address  out  ADDR_W  to RAM write_address.
- ram_write_enable  out  1  to RAM write_enable.
- ram_write_data  out  32  to RAM write_data.
- ram_read_data  in  32  from RAM read_data.
- ram_read_ready  in  1  from RAM read_ready.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_data = 0; resp_error = 0.
  - ram_write_enable = 0; ram_read_address = 0; ram_write_address = 0; ram_write_data = 0.
  - Wait counter = 0.
  - Reset mid-operation drops any in-flight request silently, with no write pulse afterwards.
- All outputs are registered. req_ready = (state == IDLE).
- IDLE, req_valid = 1, req_write = 1:
  - Next cycle: ram_write_enable = 1 for exactly one cycle, with ram_write_address = req_address and ram_write_data = req_wdata.
  - state -> WRITE, then -> RESP with resp_data = 0 and resp_error = 0.
- IDLE, req_valid = 1, req_write = 0:
  - Register ram_read_address = req_address, clear the counter, state -> WAIT_READ.
- WAIT_READ:
  - If ram_read_ready = 1: capture ram_read_data into resp_data, resp_error = 0, state -> RESP.
  - Otherwise increment the counter.
  - When the counter reaches MAX_WAIT with ram_read_ready still 0: resp_data = 0, resp_error = 1, state -> RESP.
  - If ready arrives on the same cycle the counter hits MAX_WAIT, ready wins (normal data, no error).
- RESP:
  - resp_valid = 1; resp_data and resp_error held stable until resp_ready = 1.
  - On the handshake cycle, state -> IDLE and resp_valid deasserts next cycle.
  - No new request is accepted in RESP.
- Latency with a combinational-ready RAM:
  - Load: accept at cycle N, capture at N+1, resp_valid at N+2.
  - Store: accept at N, write pulse at N+1, resp_valid at N+2.
- Ordering and hazards:
  - One outstanding request, strictly in order.
  - A store followed by a load to the same address returns the new data, because the write commits before the load's address is presented.
- ram_read_address holds its last value outside WAIT_READ (no spurious toggling). ram_write_enable is 0 in every state except WRITE.
- Counter is 8 bits, saturating, never wraps.

Decomposition:
- Shared package mem_pkg:
  - typedef enum logic [1:0] mem_state_t {IDLE, WRITE, WAIT_READ, RESP}.
  - Localparam RESP_ERR_DATA = 32'h0.
  - Response struct {data[31:0], error}.
- ADDR_W is taken from `RAM_ADDRESS_BITWIDTH in define.sv.
- One natural sub-module: ram_wait_timer (load/clear, enable, saturating compare against MAX_WAIT, expired output).

Test Plan:
- Store addr 0x10, data 0xDEADBEEF, resp_ready held 1 -> ram_write_enable high for exactly 1 cycle at N+1 with address 0x10; resp_valid at N+2 with data 0, error 0; req_ready back to 1 at N+3.
- Store 0xDEADBEEF to 0x10, then load 0x10 with a real RAM model -> resp_data = 0xDEADBEEF, resp_error = 0.
- Load with ram_read_ready held low 3 cycles, MAX_WAIT = 15 -> resp_valid 3 cycles later than the zero-stall case; data correct, error 0.
- Load with ram_read_ready held low indefinitely, MAX_WAIT = 4 -> after 4 wait cycles resp_valid = 1, resp_error = 1, resp_data = 0; no write pulse observed.
- resp_ready held low 5 cycles during RESP -> resp_valid and resp_data stable; req_ready stays 0; a req_valid asserted meanwhile is not accepted until after the handshake.
- rstn asserted asynchronously during WAIT_READ and again during WRITE -> all outputs go to reset values immediately, with no write_enable pulse after release; the next request completes normally.
